pe_sat_drain: RTL and testbench

Next-generation output-stationary processing element for the FFN systolic array.
- Forwards the A and B operands with valid tags to its neighbours.
- Multiplies the operands with an optional pipeline stage and accumulates locally, using saturating or wrapping arithmetic.
- Supports per-tile clear and a sticky overflow flag.
- Drains its result through a column shift chain, so the array can unload results without a wide output mux.

---
 rtl/pe_pkg.sv | 46 ++++
 rtl/pe_mul_stage.sv | 51 +++++
 rtl/pe_sat_drain.sv | 144 ++++++++++++++
 tb/tb_pe_sat_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared helpers for the saturating/wrapping output-stationary PE.
// Arithmetic is done in a fixed 64-bit signed domain; callers keep the low ACC_WIDTH bits.
package pe_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t val;
  } fit_t;

  function automatic int sum_width(input int acc_w, input int data_w);
    return ((acc_w > 2 * data_w) ? acc_w : 2 * data_w) + 1;
  endfunction

  function automatic wide_t acc_max(input int acc_w);
    return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int acc_w);
    return -(wide_t'(1) <<< (acc_w - 1));
  endfunction

  // Overflow is reported in both modes; wrap keeps the low acc_w bits, sign-extended.
  function automatic fit_t fit(input wide_t v, input int acc_w, input bit sat);
    fit_t  r;
    wide_t hi;
    wide_t lo;
    int    sh;
    hi    = acc_max(acc_w);
    lo    = acc_min(acc_w);
    sh    = WIDE_W - acc_w;
    r.ovf = (v > hi) || (v < lo);
    if (sat) begin
      if (v > hi)      r.val = hi;
      else if (v < lo) r.val = lo;
      else             r.val = v;
    end else begin
      r.val = (v <<< sh) >>> sh;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// Operand product with its valid/clear tag, either registered or combinational.
module pe_mul_stage
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int MUL_PIPE   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fire,
  input  logic                           clr,
  input  logic signed [DATA_WIDTH-1:0]   data_a,
  input  logic signed [DATA_WIDTH-1:0]   data_b,
  output logic signed [2*DATA_WIDTH-1:0] prod,
  output logic                           pvld,
  output logic                           pclr
);

  logic signed [2*DATA_WIDTH-1:0] prod_d;

  assign prod_d = (2*DATA_WIDTH)'(data_a) * (2*DATA_WIDTH)'(data_b);

  if (MUL_PIPE != 0) begin : g_pipe
    logic signed [2*DATA_WIDTH-1:0] prod_q;
    logic                           pvld_q;
    logic                           pclr_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        pvld_q <= 1'b0;
        pclr_q <= 1'b0;
      end else begin
        prod_q <= prod_d;
        pvld_q <= fire;
        pclr_q <= clr & fire;
      end
    end

    assign prod = prod_q;
    assign pvld = pvld_q;
    assign pclr = pclr_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign prod = prod_d;
    assign pvld = fire;
    assign pclr = clr & fire;
  end

endmodule

// File: rtl/pe_sat_drain.sv
// Output-stationary PE: operand forwarding, saturating/wrapping accumulate, sticky
// overflow and a column shift chain for unloading results.
module pe_sat_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ACC_WIDTH  = 17,
  parameter int SATURATE   = 1,
  parameter int MUL_PIPE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_vld_i,
  input  logic signed [DATA_WIDTH-1:0] data_a_i,
  input  logic                         b_vld_i,
  input  logic signed [DATA_WIDTH-1:0] data_b_i,
  input  logic                         clr_i,
  output logic                         a_vld_o,
  output logic signed [DATA_WIDTH-1:0] data_a_o,
  output logic                         b_vld_o,
  output logic signed [DATA_WIDTH-1:0] data_b_o,
  output logic                         clr_o,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic                         ovf_o,
  input  logic                         load_i,
  input  logic                         drain_i,
  input  logic signed [ACC_WIDTH-1:0]  psum_i,
  input  logic                         psum_vld_i,
  output logic signed [ACC_WIDTH-1:0]  psum_o,
  output logic                         psum_vld_o
);

  localparam int SUM_W = sum_width(ACC_WIDTH, DATA_WIDTH);

  if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_bad_acc_width
    $error("pe_sat_drain: ACC_WIDTH must be at least DATA_WIDTH+1");
  end
  if (SUM_W > WIDE_W) begin : g_bad_sum_width
    $error("pe_sat_drain: accumulator sum does not fit the 64-bit arithmetic domain");
  end

  logic                           fire;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                           pvld;
  logic                           pclr;

  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic                           ovf_q;
  logic                           ovf_d;
  logic signed [ACC_WIDTH-1:0]    psum_q;
  logic                           psum_vld_q;

  wide_t                          prod_wide;
  wide_t                          sum_wide;
  fit_t                           fit_prod;
  fit_t                           fit_sum;
  logic                           unused_fit_hi;

  assign fire = a_vld_i & b_vld_i;

  pe_mul_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_PIPE   (MUL_PIPE)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .fire   (fire),
    .clr    (clr_i),
    .data_a (data_a_i),
    .data_b (data_b_i),
    .prod   (prod),
    .pvld   (pvld),
    .pclr   (pclr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_o  <= 1'b0;
      data_a_o <= '0;
      b_vld_o  <= 1'b0;
      data_b_o <= '0;
      clr_o    <= 1'b0;
    end else begin
      a_vld_o  <= a_vld_i;
      data_a_o <= data_a_i;
      b_vld_o  <= b_vld_i;
      data_b_o <= data_b_i;
      clr_o    <= clr_i;
    end
  end

  // The first product of a tile replaces the accumulator rather than adding to it.
  always_comb begin
    prod_wide = wide_t'(prod);
    sum_wide  = wide_t'(acc_q) + prod_wide;
    fit_prod  = fit(prod_wide, ACC_WIDTH, SATURATE != 0);
    fit_sum   = fit(sum_wide, ACC_WIDTH, SATURATE != 0);
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (pvld && pclr) begin
      acc_d = fit_prod.val[ACC_WIDTH-1:0];
      ovf_d = fit_prod.ovf;
    end else if (pvld) begin
      acc_d = fit_sum.val[ACC_WIDTH-1:0];
      ovf_d = ovf_q | fit_sum.ovf;
    end else if (clr_i && !fire) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign unused_fit_hi = ^{fit_prod.val[WIDE_W-1:ACC_WIDTH], fit_sum.val[WIDE_W-1:ACC_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Load captures the post-update value so a final product landing this cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
    end else if (load_i) begin
      psum_q     <= acc_d;
      psum_vld_q <= 1'b1;
    end else if (drain_i) begin
      psum_q     <= psum_i;
      psum_vld_q <= psum_vld_i;
    end
  end

  assign acc_o      = acc_q;
  assign ovf_o      = ovf_q;
  assign psum_o     = psum_q;
  assign psum_vld_o = psum_vld_q;

endmodule

// File: tb/tb_pe_sat_drain.sv
// Bench for pe_sat_drain: a saturating pipelined PE and a wrapping combinational PE
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_pe_sat_drain;

  localparam int DW = 9;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 a_vld_i, b_vld_i, clr_i, load_i, drain_i, psum_vld_i;
  logic signed [DW-1:0] data_a_i, data_b_i;
  logic signed [AW-1:0] psum_i;

  logic                 a_vld_o [2];
  logic                 b_vld_o [2];
  logic                 clr_o [2];
  logic                 ovf_o [2];
  logic                 psum_vld_o [2];
  logic signed [DW-1:0] data_a_o [2];
  logic signed [DW-1:0] data_b_o [2];
  logic signed [AW-1:0] acc_o [2];
  logic signed [AW-1:0] psum_o [2];

  pe_sat_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1), .MUL_PIPE(1)) dut_sat (
    .clk(clk), .rst(rst),
    .a_vld_i(a_vld_i), .data_a_i(data_a_i), .b_vld_i(b_vld_i), .data_b_i(data_b_i), .clr_i(clr_i),
    .a_vld_o(a_vld_o[0]), .data_a_o(data_a_o[0]), .b_vld_o(b_vld_o[0]), .data_b_o(data_b_o[0]),
    .clr_o(clr_o[0]), .acc_o(acc_o[0]), .ovf_o(ovf_o[0]),
    .load_i(load_i), .drain_i(drain_i), .psum_i(psum_i), .psum_vld_i(psum_vld_i),
    .psum_o(psum_o[0]), .psum_vld_o(psum_vld_o[0])
  );

  pe_sat_drain #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(0), .MUL_PIPE(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .a_vld_i(a_vld_i), .data_a_i(data_a_i), .b_vld_i(b_vld_i), .data_b_i(data_b_i), .clr_i(clr_i),
    .a_vld_o(a_vld_o[1]), .data_a_o(data_a_o[1]), .b_vld_o(b_vld_o[1]), .data_b_o(data_b_o[1]),
    .clr_o(clr_o[1]), .acc_o(acc_o[1]), .ovf_o(ovf_o[1]),
    .load_i(load_i), .drain_i(drain_i), .psum_i(psum_i), .psum_vld_i(psum_vld_i),
    .psum_o(psum_o[1]), .psum_vld_o(psum_vld_o[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: instance 0 saturates with a one-cycle product delay, instance 1 wraps with none.
  bit     m_sat [2]  = '{1'b1, 1'b0};
  bit     m_pipe [2] = '{1'b1, 1'b0};
  longint m_acc [2];
  bit     m_ovf [2];
  longint m_psum [2];
  bit     m_psv [2];
  bit     prev_fire, prev_clr;
  longint prev_prod;
  bit     e_avld, e_bvld, e_clr;
  longint e_a, e_b;

  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

  function automatic bit is_ovf(input longint v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic longint fit_val(input longint v, input bit sat);
    longint w;
    if (sat) begin
      if (v > ACC_MAX) return ACC_MAX;
      if (v < ACC_MIN) return ACC_MIN;
      return v;
    end
    w = v & ((longint'(1) <<< AW) - 1);
    if (w > ACC_MAX) w = w - (longint'(1) <<< AW);
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_ovf[c] = 0; m_psum[c] = 0; m_psv[c] = 0;
    end
    prev_fire = 0; prev_clr = 0; prev_prod = 0;
    e_avld = 0; e_bvld = 0; e_clr = 0; e_a = 0; e_b = 0;
  endtask

  task automatic model_edge();
    bit     fire, pv, pc, novf;
    longint p, pp, raw, nacc;
    fire = a_vld_i && b_vld_i;
    p    = longint'(data_a_i) * longint'(data_b_i);
    for (int c = 0; c < 2; c++) begin
      pv = m_pipe[c] ? prev_fire : fire;
      pc = m_pipe[c] ? prev_clr  : (clr_i && fire);
      pp = m_pipe[c] ? prev_prod : p;
      nacc = m_acc[c];
      novf = m_ovf[c];
      if (pv) begin
        raw  = (pc ? 0 : m_acc[c]) + pp;
        nacc = fit_val(raw, m_sat[c]);
        novf = (pc ? 1'b0 : m_ovf[c]) | is_ovf(raw);
      end else if (clr_i && !fire) begin
        nacc = 0;
        novf = 0;
      end
      if (load_i) begin
        m_psum[c] = nacc; m_psv[c] = 1;
      end else if (drain_i) begin
        m_psum[c] = longint'(psum_i); m_psv[c] = psum_vld_i;
      end
      m_acc[c] = nacc;
      m_ovf[c] = novf;
    end
    prev_fire = fire;
    prev_clr  = clr_i && fire;
    prev_prod = p;
    e_avld = a_vld_i; e_bvld = b_vld_i; e_clr = clr_i;
    e_a = longint'(data_a_i); e_b = longint'(data_b_i);
  endtask

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("acc_o[%0d]", c), acc_o[c], m_acc[c]);
      chk($sformatf("ovf_o[%0d]", c), ovf_o[c], m_ovf[c]);
      chk($sformatf("psum_o[%0d]", c), psum_o[c], m_psum[c]);
      chk($sformatf("psum_vld_o[%0d]", c), psum_vld_o[c], m_psv[c]);
      chk($sformatf("a_vld_o[%0d]", c), a_vld_o[c], e_avld);
      chk($sformatf("b_vld_o[%0d]", c), b_vld_o[c], e_bvld);
      chk($sformatf("clr_o[%0d]", c), clr_o[c], e_clr);
      chk($sformatf("data_a_o[%0d]", c), data_a_o[c], e_a);
      chk($sformatf("data_b_o[%0d]", c), data_b_o[c], e_b);
    end
  endtask

  task automatic set_in(input bit av, input int a, input bit bv, input int b, input bit clr,
                        input bit ld, input bit dr, input int ps, input bit psv);
    a_vld_i = av; data_a_i = a[DW-1:0];
    b_vld_i = bv; data_b_i = b[DW-1:0];
    clr_i = clr; load_i = ld; drain_i = dr;
    psum_i = ps[AW-1:0]; psum_vld_i = psv;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    bit     av; int a; bit bv; int b; bit clr;
    longint acc0; bit ovf0; longint acc1; bit ovf1; bit avo; bit bvo;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1, 3, 1, -4, 1,        0, 0,    -12, 0, 1, 1};
    tbl[1]  = '{1, 3, 1, -4, 0,      -12, 0,    -24, 0, 1, 1};
    tbl[2]  = '{1, 3, 1, -4, 0,      -24, 0,    -36, 0, 1, 1};
    tbl[3]  = '{1, 3, 1, -4, 0,      -36, 0,    -48, 0, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0,       -48, 0,    -48, 0, 0, 0};
    tbl[5]  = '{1, -256, 1, -256, 1, -48, 0, -65536, 1, 1, 1};
    tbl[6]  = '{1, 1, 1, -1, 0,    65535, 1,  65535, 1, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 0,     65534, 1,  65535, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1,         0, 0,      0, 0, 0, 0};
    tbl[9]  = '{1, 5, 0, 7, 0,         0, 0,      0, 0, 1, 0};
    tbl[10] = '{1, 5, 0, 7, 0,         0, 0,      0, 0, 1, 0};
    tbl[11] = '{1, 5, 0, 7, 0,         0, 0,      0, 0, 1, 0};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].av, tbl[i].a, tbl[i].bv, tbl[i].b, tbl[i].clr, 0, 0, 0, 0);
      step();
      chk($sformatf("vec%0d acc_sat", i), acc_o[0], tbl[i].acc0);
      chk($sformatf("vec%0d ovf_sat", i), ovf_o[0], tbl[i].ovf0);
      chk($sformatf("vec%0d acc_wrap", i), acc_o[1], tbl[i].acc1);
      chk($sformatf("vec%0d ovf_wrap", i), ovf_o[1], tbl[i].ovf1);
      chk($sformatf("vec%0d a_vld_o", i), a_vld_o[0], tbl[i].avo);
      chk($sformatf("vec%0d b_vld_o", i), b_vld_o[0], tbl[i].bvo);
    end

    // Drain chain: load, shift, then load and drain together.
    set_in(1, 10, 1, 10, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("load psum[%0d]", c), psum_o[c], 100);
      chk($sformatf("load psum_vld[%0d]", c), psum_vld_o[c], 1);
    end
    set_in(0, 0, 0, 0, 0, 0, 1, -7, 1);
    step();
    for (int c = 0; c < 2; c++) chk($sformatf("drain psum[%0d]", c), psum_o[c], -7);
    set_in(0, 0, 0, 0, 0, 1, 1, 55, 0);
    step();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("load_wins psum[%0d]", c), psum_o[c], 100);
      chk($sformatf("load_wins vld[%0d]", c), psum_vld_o[c], 1);
    end

    // Asynchronous reset in the middle of a tile, then a non-clear pair.
    set_in(1, 7, 1, 7, 1, 0, 0, 0, 0);
    step();
    set_in(1, 7, 1, 7, 0, 0, 0, 0, 0);
    step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int c = 0; c < 2; c++) chk($sformatf("rst acc[%0d]", c), acc_o[c], 0);
    set_in(1, 2, 1, 2, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    chk("post_rst acc_wrap", acc_o[1], 4);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post_rst acc_sat", acc_o[0], 4);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int a, b, ps;
      bit wide;
      wide = ($urandom_range(1) == 1);
      a  = wide ? int'($urandom_range(511)) - 256 : int'($urandom_range(15)) - 8;
      b  = wide ? int'($urandom_range(511)) - 256 : int'($urandom_range(15)) - 8;
      ps = int'($urandom_range(131071)) - 65536;
      set_in($urandom_range(3) != 0, a, $urandom_range(3) != 0, b, $urandom_range(7) == 0,
             $urandom_range(9) == 0, $urandom_range(3) == 0, ps, $urandom_range(1) == 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
